// File: rtl/matvec_sched.sv
// Row-at-a-time scheduler driving a shared 16-lane dot engine to compute y = M*b.
// Fetches each row, pulses engine reset then start, waits for done with a timeout, streams results.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// FETCH    | row-store read strobe for the current row
// WAIT_ROW | row data returns, captured into dot_a
// CLR      | engine reset pulse, clears sticky done
// START    | engine start pulse, timeout reloaded
// RUN      | waiting for engine done or timeout
// EMIT     | result presented until consumer accepts
module matvec_sched #(
    parameter int MAX_ROWS    = 16,
    parameter int DOT_TIMEOUT = 8192,
    localparam int ROW_W      = $clog2(MAX_ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ROW_W-1:0] cmd_rows,
    input  logic [127:0]     cmd_vec,
    output logic             row_rd_en,
    output logic [ROW_W-1:0] row_addr,
    input  logic [127:0]     row_data,
    output logic             dot_rst_n,
    output logic             dot_start,
    output logic [127:0]     dot_a,
    output logic [127:0]     dot_b,
    input  logic [15:0]      dot_c,
    input  logic             dot_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [ROW_W-1:0] res_row,
    output logic             res_last,
    output logic             busy,
    output logic             err
);

    localparam int TMO_W = $clog2(DOT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_ROW, CLR, START, RUN, EMIT
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] rows;
    logic [ROW_W-1:0] row_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [ROW_W-1:0] rows_clamped;

    assign rows_clamped = (cmd_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : cmd_rows;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rows      <= '0;
            row_cnt   <= '0;
            tmo_cnt   <= '0;
            cmd_ready <= 1'b1;
            row_rd_en <= 1'b0;
            row_addr  <= '0;
            dot_rst_n <= 1'b1;
            dot_start <= 1'b0;
            dot_a     <= '0;
            dot_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
            res_last  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dot_b   <= cmd_vec;
                        rows    <= rows_clamped;
                        row_cnt <= '0;
                        err     <= 1'b0;
                        if (rows_clamped != '0) begin
                            state     <= FETCH;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            row_rd_en <= 1'b1;
                            row_addr  <= '0;
                        end
                    end
                end
                FETCH: begin
                    row_rd_en <= 1'b0;
                    state     <= WAIT_ROW;
                end
                WAIT_ROW: begin
                    dot_a     <= row_data;
                    dot_rst_n <= 1'b0;
                    state     <= CLR;
                end
                CLR: begin
                    dot_rst_n <= 1'b1;
                    dot_start <= 1'b1;
                    tmo_cnt   <= TMO_W'(DOT_TIMEOUT);
                    state     <= START;
                end
                START: begin
                    dot_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (dot_done) begin
                        res_data  <= dot_c;
                        res_row   <= row_cnt;
                        res_last  <= (row_cnt == rows - ROW_W'(1));
                        res_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (tmo_cnt == TMO_W'(1)) begin
                        // Engine hung: drop the rest of the command without presenting a result.
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_last) begin
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            row_cnt   <= row_cnt + ROW_W'(1);
                            row_addr  <= row_cnt + ROW_W'(1);
                            row_rd_en <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_sched.sv
// Directed bench for matvec_sched with a behavioural row store and dot engine.
module tb_matvec_sched;

    localparam int ROW_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [ROW_W-1:0] cmd_rows = '0;
    logic [127:0]     cmd_vec = '0;
    logic             row_rd_en;
    logic [ROW_W-1:0] row_addr;
    logic [127:0]     row_data = '0;
    logic             dot_rst_n;
    logic             dot_start;
    logic [127:0]     dot_a;
    logic [127:0]     dot_b;
    logic [15:0]      dot_c = '0;
    logic             dot_done = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic [ROW_W-1:0] res_row;
    logic             res_last;
    logic             busy;
    logic             err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matvec_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows), .cmd_vec(cmd_vec),
        .row_rd_en(row_rd_en), .row_addr(row_addr), .row_data(row_data),
        .dot_rst_n(dot_rst_n), .dot_start(dot_start), .dot_a(dot_a), .dot_b(dot_b),
        .dot_c(dot_c), .dot_done(dot_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_last(res_last), .busy(busy), .err(err)
    );

    logic [127:0] mem [16];
    always @(posedge clk) if (row_rd_en) row_data <= mem[row_addr[3:0]];

    function automatic logic [15:0] dotp(input logic [127:0] a, input logic [127:0] b);
        logic [15:0] s = '0;
        for (int j = 0; j < 16; j++) s += 16'(a[8*j+:8]) * 16'(b[8*j+:8]);
        return s;
    endfunction

    int          eng_lat = 1;
    bit          eng_hang = 1'b0;
    int          eng_cnt = 0;
    logic [15:0] eng_res = '0;
    always @(posedge clk) begin
        if (!dot_rst_n || !rst_n) begin
            dot_done <= 1'b0;
            dot_c    <= '0;
            eng_cnt  <= 0;
        end else if (dot_start) begin
            eng_cnt <= eng_lat;
            eng_res <= dotp(dot_a, dot_b);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_hang) begin
                dot_done <= 1'b1;
                dot_c    <= eng_res;
            end
        end
    end

    // Start contract: engine reset the cycle before start, operands stable through EMIT.
    int           viol = 0;
    logic         prev_rst = 1'b1;
    bit           in_op = 1'b0;
    logic [127:0] snap_a, snap_b;
    always @(negedge clk) begin
        if (dot_start) begin
            if (prev_rst !== 1'b0) viol++;
            snap_a = dot_a;
            snap_b = dot_b;
            in_op  = 1'b1;
        end else if (in_op) begin
            if (row_rd_en || !busy) in_op = 1'b0;
            else if (dot_a !== snap_a || dot_b !== snap_b) viol++;
        end
        prev_rst = dot_rst_n;
    end

    task automatic send_cmd(input logic [ROW_W-1:0] rows, input logic [127:0] vec);
        int n = 0;
        cmd_rows  = rows;
        cmd_vec   = vec;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        int n = 0;
        while (!res_valid && n < 10000) begin @(negedge clk); n++; end
        ok = res_valid;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic load_rows_inc();
        for (int r = 0; r < 16; r++) mem[r] = {16{8'(r + 1)}};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({cmd_ready, dot_rst_n, row_rd_en, dot_start, res_valid, res_last, busy, err} !== 8'b1100_0000 ||
            dot_a !== '0 || dot_b !== '0 || res_data !== '0 || res_row !== '0 || row_addr !== '0) begin
            failures++;
            $display("FAIL reset_values: flags=%b res_data=%0d res_row=%0d required flags=11000000 and zero buses",
                     {cmd_ready, dot_rst_n, row_rd_en, dot_start, res_valid, res_last, busy, err}, res_data, res_row);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k = 0;
        bit ok;
        mem[0]  = {16{8'h01}};
        eng_lat = 1;
        send_cmd(5'd1, {16{8'h02}});
        while (!res_valid && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (k != 6) begin failures++; $display("FAIL single_latency: got %0d cycles, required 6", k); end
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd32 || res_row !== 5'd0 || res_last !== 1'b1) begin
            failures++;
            $display("FAIL single_result: valid=%b data=%0d row=%0d last=%b required 1/32/0/1", ok, res_data, res_row, res_last);
        end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_emit: got %b required 1", busy); end
        consume();
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done: busy=%b cmd_ready=%b res_valid=%b required 0/1/0", busy, cmd_ready, res_valid);
        end
    endtask

    task automatic test_multi();
        logic [15:0] exp_d [4] = '{16'd16, 16'd32, 16'd48, 16'd64};
        bit ok;
        load_rows_inc();
        eng_lat = 3;
        send_cmd(5'd4, {16{8'h01}});
        for (int r = 0; r < 4; r++) begin
            wait_res(ok);
            checks++;
            if (!ok || res_data !== exp_d[r] || res_row !== 5'(r) || res_last !== (r == 3)) begin
                failures++;
                $display("FAIL multi_row%0d: valid=%b data=%0d row=%0d last=%b required data=%0d row=%0d last=%0d",
                         r, ok, res_data, res_row, res_last, exp_d[r], r, (r == 3));
            end
            consume();
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL multi_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_stall();
        logic [15:0] exp_d [4] = '{16'd16, 16'd32, 16'd48, 16'd64};
        logic [15:0] d0;
        logic [4:0]  r0;
        logic        l0;
        bit ok;
        bit bad;
        load_rows_inc();
        eng_lat = 2;
        send_cmd(5'd4, {16{8'h01}});
        for (int r = 0; r < 4; r++) begin
            wait_res(ok);
            d0 = res_data; r0 = res_row; l0 = res_last;
            bad = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_data !== d0 || res_row !== r0 || res_last !== l0 || row_rd_en !== 1'b0)
                    bad = 1'b1;
            end
            checks++;
            if (!ok || bad || d0 !== exp_d[r] || r0 !== 5'(r) || l0 !== (r == 3)) begin
                failures++;
                $display("FAIL stall_row%0d: unstable=%b data=%0d row=%0d last=%b required stable data=%0d row=%0d last=%0d",
                         r, bad, d0, r0, l0, exp_d[r], r, (r == 3));
            end
            consume();
        end
    endtask

    task automatic test_zero_rows();
        bit saw_valid = 1'b0;
        bit saw_start = 1'b0;
        bit not_ready = 1'b0;
        send_cmd(5'd0, {16{8'h05}});
        for (int c = 0; c < 20; c++) begin
            if (res_valid) saw_valid = 1'b1;
            if (dot_start) saw_start = 1'b1;
            if (!cmd_ready || busy) not_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_valid || saw_start || not_ready) begin
            failures++;
            $display("FAIL zero_rows: res_valid_seen=%b dot_start_seen=%b not_idle=%b required 0/0/0", saw_valid, saw_start, not_ready);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit saw_valid = 1'b0;
        bit ok;
        eng_hang = 1'b1;
        eng_lat  = 1;
        send_cmd(5'd2, {16{8'h01}});
        while (!err && n < 9000) begin
            if (res_valid) saw_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || saw_valid) begin
            failures++;
            $display("FAIL timeout_abort: err=%b busy=%b cmd_ready=%b res_valid_seen=%b after %0d cycles required 1/0/1/0",
                     err, busy, cmd_ready, saw_valid, n);
        end
        checks++;
        if (n < 8192) begin failures++; $display("FAIL timeout_early: err after %0d cycles, required >= 8192", n); end
        eng_hang = 1'b0;
        mem[0]   = {16{8'h01}};
        send_cmd(5'd1, {16{8'h02}});
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: got %b required 0", err); end
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd32 || res_last !== 1'b1) begin
            failures++;
            $display("FAIL timeout_recover: valid=%b data=%0d last=%b required 1/32/1", ok, res_data, res_last);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        load_rows_inc();
        eng_lat = 30;
        send_cmd(5'd4, {16{8'h01}});
        for (int r = 0; r < 2; r++) begin wait_res(ok); consume(); end
        while (!(dot_start && row_addr == 5'd2) && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n >= 200) begin failures++; $display("FAIL reset_mid_reach: row 2 start not seen within %0d cycles", n); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, dot_rst_n, row_rd_en, dot_start, res_valid, res_last, busy, err} !== 8'b1100_0000 ||
            dot_a !== '0 || dot_b !== '0 || res_data !== '0 || res_row !== '0 || row_addr !== '0) begin
            failures++;
            $display("FAIL reset_mid_values: flags=%b res_data=%0d res_row=%0d required flags=11000000 and zero buses",
                     {cmd_ready, dot_rst_n, row_rd_en, dot_start, res_valid, res_last, busy, err}, res_data, res_row);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        eng_lat = 1;
        @(negedge clk);
        send_cmd(5'd2, {16{8'h03}});
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd48 || res_row !== 5'd0 || res_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_row0: valid=%b data=%0d row=%0d last=%b required 1/48/0/0", ok, res_data, res_row, res_last);
        end
        consume();
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd96 || res_row !== 5'd1 || res_last !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_row1: valid=%b data=%0d row=%0d last=%b required 1/96/1/1", ok, res_data, res_row, res_last);
        end
        consume();
    endtask

    task automatic test_start_contract();
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL start_contract: %0d violations, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero_rows();
        test_timeout();
        test_reset_mid();
        test_start_contract();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
